// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline stages.
//   mem_state_t : MEM-stage access sequencer states
//   ex_mem_t    : EX/MEM pipeline register contents
//   mem_wb_t    : MEM/WB pipeline register contents
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_t;

  typedef struct packed {
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  mem_write;
    logic                  mem_read;
    logic [WORD_W-1:0]     alu_result;
    logic [WORD_W-1:0]     write_data;
    logic [REG_ADDR_W-1:0] dest;
  } ex_mem_t;

  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dest;
    logic [WORD_W-1:0]     data;
    logic                  misalign;
  } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Single-port data RAM: synchronous write, asynchronous read.
// Contents start at zero and are never touched by reset.
//   clk   : write clock
//   we    : write enable (sampled on rising edge)
//   addr  : word index
//   wdata : write word
//   rdata : combinational read of mem[addr]
module data_memory
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline.
// Holds the EX/MEM register, sequences loads/stores on the data RAM with
// MEM_LATENCY wait cycles, and produces the MEM/WB register.
// Optional build macro: MEM_ALIGN_CHECK_EN (misaligned accesses flagged,
// stores suppressed, load data forced to 0).
//   clk, reset (async, active-low)
//   *ExOutput / *Ex          : instruction arriving from EX
//   memStall                 : freeze IF/ID/EX and EX/MEM while access pending
//   aluResultMem, regWriteMem, regWriteRegisterMem, memReadMem : EX/MEM taps
//   regWriteWb, writeRegisterWb, regWriteDataWb, misalignWb    : MEM/WB
module memory_access
  import mips_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memToRegExOutput,
  input  logic                  regWriteExOutput,
  input  logic                  memWriteExOutput,
  input  logic                  memReadExOutput,
  input  logic [WORD_W-1:0]     aluResultEx,
  input  logic [WORD_W-1:0]     memWriteDataEx,
  input  logic [REG_ADDR_W-1:0] regWriteRegisterEx,
  output logic                  memStall,
  output logic [WORD_W-1:0]     aluResultMem,
  output logic                  regWriteMem,
  output logic [REG_ADDR_W-1:0] regWriteRegisterMem,
  output logic                  memReadMem,
  output logic                  regWriteWb,
  output logic [REG_ADDR_W-1:0] writeRegisterWb,
  output logic [WORD_W-1:0]     regWriteDataWb,
  output logic                  misalignWb
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  mem_wb_t          mem_wb_q, mem_wb_d;

  logic              access;
  logic              complete;
  logic              stall;
  logic              misalign;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] load_data;

  assign access = ex_mem_q.mem_read | ex_mem_q.mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = access & (ex_mem_q.alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Access sequencer: stall is high for MEM_LATENCY cycles, then one
  // completion cycle in which the store commits and load data is taken.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (access) begin
          if (MEM_LATENCY > 0) begin
            stall   = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = MEM_WAIT;
          end else begin
            complete = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          complete = 1'b1;
          state_d  = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Store only at completion, so an access aborted by reset never writes.
  assign ram_we    = complete & ex_mem_q.mem_write & ~misalign;
  assign load_data = misalign ? '0 : ram_rdata;

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall) begin
      ex_mem_d.mem_to_reg = memToRegExOutput;
      ex_mem_d.reg_write  = regWriteExOutput;
      ex_mem_d.mem_write  = memWriteExOutput;
      ex_mem_d.mem_read   = memReadExOutput;
      ex_mem_d.alu_result = aluResultEx;
      ex_mem_d.write_data = memWriteDataEx;
      ex_mem_d.dest       = regWriteRegisterEx;
    end
  end

  // Stalled edges load a bubble so a pending instruction writes back once.
  always_comb begin
    mem_wb_d = '0;
    if (!stall) begin
      mem_wb_d.reg_write = ex_mem_q.reg_write & (ex_mem_q.dest != '0);
      mem_wb_d.dest      = ex_mem_q.dest;
      mem_wb_d.data      = ex_mem_q.mem_to_reg ? load_data : ex_mem_q.alu_result;
      mem_wb_d.misalign  = misalign;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= MEM_IDLE;
      cnt_q    <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  data_memory #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_memory (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ex_mem_q.alu_result[ADDR_W+1:2]),
    .wdata (ex_mem_q.write_data),
    .rdata (ram_rdata)
  );

  assign memStall            = stall;
  assign aluResultMem        = ex_mem_q.alu_result;
  assign regWriteMem         = ex_mem_q.reg_write;
  assign regWriteRegisterMem = ex_mem_q.dest;
  assign memReadMem          = ex_mem_q.mem_read;
  assign regWriteWb          = mem_wb_q.reg_write;
  assign writeRegisterWb     = mem_wb_q.dest;
  assign regWriteDataWb      = mem_wb_q.data;
  assign misalignWb          = mem_wb_q.misalign;

endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access, run at MEM_LATENCY=0 and =2 in parallel.
module tb_memory_access;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LAT = 2 * g;

    typedef struct packed {
      logic        rw;
      logic [4:0]  wr;
      logic [31:0] data;
      logic        mis;
    } exp_t;

    logic        reset;
    logic        memToRegExOutput, regWriteExOutput, memWriteExOutput, memReadExOutput;
    logic [31:0] aluResultEx, memWriteDataEx;
    logic [4:0]  regWriteRegisterEx;
    logic        memStall;
    logic [31:0] aluResultMem;
    logic        regWriteMem;
    logic [4:0]  regWriteRegisterMem;
    logic        memReadMem;
    logic        regWriteWb;
    logic [4:0]  writeRegisterWb;
    logic [31:0] regWriteDataWb;
    logic        misalignWb;

    exp_t sb_q[$];
    logic done = 1'b0;
    logic prev_access;

    memory_access #(.DEPTH(256), .MEM_LATENCY(LAT)) dut (
      .clk                 (clk),
      .reset               (reset),
      .memToRegExOutput    (memToRegExOutput),
      .regWriteExOutput    (regWriteExOutput),
      .memWriteExOutput    (memWriteExOutput),
      .memReadExOutput     (memReadExOutput),
      .aluResultEx         (aluResultEx),
      .memWriteDataEx      (memWriteDataEx),
      .regWriteRegisterEx  (regWriteRegisterEx),
      .memStall            (memStall),
      .aluResultMem        (aluResultMem),
      .regWriteMem         (regWriteMem),
      .regWriteRegisterMem (regWriteRegisterMem),
      .memReadMem          (memReadMem),
      .regWriteWb          (regWriteWb),
      .writeRegisterWb     (writeRegisterWb),
      .regWriteDataWb      (regWriteDataWb),
      .misalignWb          (misalignWb)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL lat%0d %s: got %h expected %h", LAT, name, act, exp);
      end
    endtask

    function automatic logic [127:0] all_outs();
      return 128'({memStall, aluResultMem, regWriteMem, regWriteRegisterMem, memReadMem,
                   regWriteWb, writeRegisterWb, regWriteDataWb, misalignWb});
    endfunction

    task automatic drive_nop();
      memToRegExOutput   = 1'b0;
      regWriteExOutput   = 1'b0;
      memWriteExOutput   = 1'b0;
      memReadExOutput    = 1'b0;
      aluResultEx        = '0;
      memWriteDataEx     = '0;
      regWriteRegisterEx = '0;
    endtask

    task automatic push_exp(input logic rw, input logic [4:0] wr, input logic [31:0] data,
                            input logic mis);
      exp_t e;
      e = '{rw: rw, wr: wr, data: data, mis: mis};
      sb_q.push_back(e);
    endtask

    // Present one instruction in EX and hold it until EX/MEM accepts it;
    // the stall seen meanwhile belongs to the previous instruction.
    task automatic issue(input logic mtr, input logic rw, input logic mw, input logic mr,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
      int n = 0;
      memToRegExOutput   = mtr;
      regWriteExOutput   = rw;
      memWriteExOutput   = mw;
      memReadExOutput    = mr;
      aluResultEx        = alu;
      memWriteDataEx     = wd;
      regWriteRegisterEx = wr;
      while (1) begin
        @(negedge clk);
        if (!memStall) break;
        n++;
        if (n > 20) break;
      end
      check("stall_cycles", 128'(n), 128'(prev_access ? LAT : 0));
      prev_access = mw | mr;
      @(posedge clk);
      #1;
    endtask

    always @(negedge clk) begin : monitor
      exp_t e;
      if (reset && (regWriteWb || misalignWb)) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL lat%0d wb_unexpected: got rw=%0b r%0d data=%h mis=%0b required none",
                   LAT, regWriteWb, writeRegisterWb, regWriteDataWb, misalignWb);
        end else begin
          e = sb_q.pop_front();
          check("wb", 128'({regWriteWb, writeRegisterWb, regWriteDataWb, misalignWb}), 128'(e));
        end
      end
    end

    initial begin
      reset = 1'b0;
      prev_access = 1'b0;
      drive_nop();
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", all_outs(), '0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      // Store aborted by reset while pending
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h55, 5'd0);
      if (LAT > 0) begin
        @(posedge clk);
        #1;
      end
      drive_nop();
      reset = 1'b0;
      #1;
      check("reset_mid_access", all_outs(), '0);
      @(posedge clk);
      @(negedge clk) reset = 1'b1;
      prev_access = 1'b0;
      @(posedge clk);
      #1;

      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 5'd0);
      push_exp(1'b1, 5'd8, 32'hDEADBEEF, 1'b0);
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd8);
      push_exp(1'b1, 5'd3, 32'h7, 1'b0);
      issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 5'd3);
      push_exp(1'b1, 5'd9, 32'h0, 1'b0);
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 5'd9);
      issue(1'b0, 1'b1, 1'b0, 1'b0, 32'h9, 32'h0, 5'd0);
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h1234, 5'd0);
      push_exp(1'b1, 5'd10, 32'h1234, 1'b0);
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 5'd10);
`ifdef MEM_ALIGN_CHECK_EN
      push_exp(1'b0, 5'd0, 32'h41, 1'b1);
`endif
      issue(1'b0, 1'b0, 1'b1, 1'b0, 32'h41, 32'hCAFEF00D, 5'd0);
`ifdef MEM_ALIGN_CHECK_EN
      push_exp(1'b1, 5'd11, 32'hDEADBEEF, 1'b0);
`else
      push_exp(1'b1, 5'd11, 32'hCAFEF00D, 1'b0);
`endif
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd11);
`ifdef MEM_ALIGN_CHECK_EN
      push_exp(1'b1, 5'd12, 32'h0, 1'b1);
`else
      push_exp(1'b1, 5'd12, 32'hCAFEF00D, 1'b0);
`endif
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h42, 32'h0, 5'd12);
      push_exp(1'b1, 5'd13, 32'h0, 1'b0);
      issue(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 32'h77, 5'd13);
      push_exp(1'b1, 5'd14, 32'h77, 1'b0);
      issue(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 5'd14);
      repeat (3) issue(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", 128'(sb_q.size()), '0);
      done = 1'b1;
    end
  end

  initial begin
    int cyc = 0;
    while (!(g_lat[0].done && g_lat[1].done) && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    if (!(g_lat[0].done && g_lat[1].done)) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: got done=%0b%0b required 11", g_lat[1].done, g_lat[0].done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
